// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Each queue entry is a write-back request: a register id plus its data.
package rf_pkg;

  localparam int NUM_REGS = 16;
  localparam int RW       = $clog2(NUM_REGS);
  localparam int DW       = 16;
  localparam int DEPTH    = 2;

  localparam logic [RW-1:0] REG_ZERO = 4'd0;

  // Write-back request; "rid" is the destination register (reg is a keyword).
  typedef struct packed {
    logic [RW-1:0] rid;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  function automatic logic ent_hit(input logic          vld,
                                   input logic [RW-1:0] rid,
                                   input logic [RW-1:0] src);
    return vld & (rid == src) & (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry write-back request FIFO; slot 0 is always the head, and the
// per-slot valid/register vectors feed the hazard compare in the top level.
module wb_fifo2
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  wb_req_t              din,
  output wb_req_t              head,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           ent_vld,
  output logic [1:0][RW-1:0]   ent_rid
);

  wb_req_t [1:0] mem_q, mem_d;
  logic    [1:0] cnt_q, cnt_d;
  logic          push_s, pop_s;

  // Next-state for slots and occupancy; a pop shifts slot 1 into the head.
  always_comb begin
    push_s = push & (cnt_q != 2'd2);
    pop_s  = pop & (cnt_q != 2'd0);
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          mem_d[0] = din;
        end else begin
          mem_d[1] = din;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          mem_d[0] = din;
        end else begin
          mem_d[0] = mem_q[1];
          mem_d[1] = din;
        end
      end
      default: begin
        mem_d = mem_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= {(2 * $bits(wb_req_t)){1'b0}};
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head       = mem_q[0];
  assign full       = (cnt_q == 2'd2);
  assign empty      = (cnt_q == 2'd0);
  assign ent_vld    = {cnt_q == 2'd2, cnt_q != 2'd0};
  assign ent_rid[0] = mem_q[0].rid;
  assign ent_rid[1] = mem_q[1].rid;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter between the load-return (A) and execute (B) write-back
// queues, driving the single register-file write port through a flop stage.
module rf_wb_arbiter #(
  parameter int DW    = 16,
  parameter int RW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [RW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [RW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  input  logic          hold,
  input  logic [RW-1:0] SrcReg1,
  input  logic [RW-1:0] SrcReg2,
  output logic          pend1,
  output logic          pend2,
  output logic          WriteReg,
  output logic [RW-1:0] DstReg,
  output logic [DW-1:0] DstData
);

  import rf_pkg::*;

  wb_req_t                a_din_s, b_din_s, a_head_s, b_head_s;
  logic                   a_full_s, b_full_s, a_empty_s, b_empty_s;
  logic                   a_push_s, b_push_s, grant_a_s, grant_b_s;
  logic [DEPTH-1:0]       a_vld_s, b_vld_s;
  logic [DEPTH-1:0][RW-1:0] a_rid_s, b_rid_s;

  prio_e                  prio_q, prio_d;
  logic                   we_q, we_d;
  logic [RW-1:0]          dst_reg_q, dst_reg_d;
  logic [DW-1:0]          dst_data_q, dst_data_d;
  logic                   pend1_s, pend2_s;

  // Writes to R0 are acknowledged but never enter a queue.
  assign a_ready  = ~a_full_s;
  assign b_ready  = ~b_full_s;
  assign a_push_s = a_valid & ~a_full_s & (a_reg != REG_ZERO);
  assign b_push_s = b_valid & ~b_full_s & (b_reg != REG_ZERO);
  assign a_din_s  = '{rid: a_reg, data: a_data};
  assign b_din_s  = '{rid: b_reg, data: b_data};

  wb_fifo2 u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push    (a_push_s),
    .pop     (grant_a_s),
    .din     (a_din_s),
    .head    (a_head_s),
    .full    (a_full_s),
    .empty   (a_empty_s),
    .ent_vld (a_vld_s),
    .ent_rid (a_rid_s)
  );

  wb_fifo2 u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push    (b_push_s),
    .pop     (grant_b_s),
    .din     (b_din_s),
    .head    (b_head_s),
    .full    (b_full_s),
    .empty   (b_empty_s),
    .ent_vld (b_vld_s),
    .ent_rid (b_rid_s)
  );

  // Grant selection and priority update; every grant hands priority across.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    prio_d    = prio_q;
    if (!hold) begin
      if (!a_empty_s && (b_empty_s || (prio_q == PRIO_A))) begin
        grant_a_s = 1'b1;
        prio_d    = PRIO_B;
      end else if (!b_empty_s) begin
        grant_b_s = 1'b1;
        prio_d    = PRIO_A;
      end else begin
        prio_d    = prio_q;
      end
    end else begin
      prio_d = prio_q;
    end
  end

  // Output stage next-state; address and data hold between grants.
  always_comb begin
    we_d       = grant_a_s | grant_b_s;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    if (grant_a_s) begin
      dst_reg_d  = a_head_s.rid;
      dst_data_d = a_head_s.data;
    end else if (grant_b_s) begin
      dst_reg_d  = b_head_s.rid;
      dst_data_d = b_head_s.data;
    end else begin
      dst_reg_d  = dst_reg_q;
      dst_data_d = dst_data_q;
    end
  end

  // Priority and output-stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= PRIO_A;
      we_q       <= 1'b0;
      dst_reg_q  <= {RW{1'b0}};
      dst_data_q <= {DW{1'b0}};
    end else begin
      prio_q     <= prio_d;
      we_q       <= we_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
    end
  end

  // Only queued entries count; the staged write is covered by RF forwarding.
  always_comb begin
    pend1_s = 1'b0;
    pend2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend1_s = pend1_s | ent_hit(a_vld_s[i], a_rid_s[i], SrcReg1)
                        | ent_hit(b_vld_s[i], b_rid_s[i], SrcReg1);
      pend2_s = pend2_s | ent_hit(a_vld_s[i], a_rid_s[i], SrcReg2)
                        | ent_hit(b_vld_s[i], b_rid_s[i], SrcReg2);
    end
  end

  assign pend1    = pend1_s;
  assign pend2    = pend2_s;
  assign WriteReg = we_q;
  assign DstReg   = dst_reg_q;
  assign DstData  = dst_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random stimulus for rf_wb_arbiter, checked every cycle against
// a queue-based reference of the write-back rules.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, hold;
  logic        a_ready, b_ready;
  logic [3:0]  a_reg, b_reg, SrcReg1, SrcReg2;
  logic [15:0] a_data, b_data;
  logic        pend1, pend2, WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;

  rf_wb_arbiter #(.DW(16), .RW(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .hold     (hold),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .pend1    (pend1),
    .pend2    (pend2),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rid;
    logic [15:0] data;
  } ment_t;

  // Reference state: per-port queues, who goes first on a tie, and the write
  // the register file should see in the current cycle.
  ment_t       qa[$];
  ment_t       qb[$];
  bit          b_first = 1'b0;
  bit          exp_we = 1'b0;
  logic [3:0]  exp_reg = 4'd0;
  logic [15:0] exp_data = 16'd0;
  bit          a_acc_last, b_acc_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pend(input logic [3:0] src);
    bit hit = 1'b0;
    if (src == 4'd0) return 1'b0;
    foreach (qa[i]) if (qa[i].rid == src) hit = 1'b1;
    foreach (qb[i]) if (qb[i].rid == src) hit = 1'b1;
    return hit;
  endfunction

  // One clock: compare against the reference mid-cycle, then advance both.
  task automatic step();
    int  sa, sb;
    bit  ga, gb;
    ment_t e;
    @(negedge clk);
    check("a_ready", 32'(a_ready), 32'(qa.size() < 2));
    check("b_ready", 32'(b_ready), 32'(qb.size() < 2));
    check("pend1", 32'(pend1), 32'(model_pend(SrcReg1)));
    check("pend2", 32'(pend2), 32'(model_pend(SrcReg2)));
    check("WriteReg", 32'(WriteReg), 32'(exp_we));
    check("DstReg", 32'(DstReg), 32'(exp_reg));
    check("DstData", 32'(DstData), 32'(exp_data));
    a_acc_last = 1'b0;
    b_acc_last = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
      b_first  = 1'b0;
      exp_we   = 1'b0;
      exp_reg  = 4'd0;
      exp_data = 16'd0;
    end else begin
      sa = qa.size();
      sb = qb.size();
      ga = !hold && sa > 0 && (sb == 0 || !b_first);
      gb = !hold && sb > 0 && !ga;
      exp_we = ga || gb;
      if (ga) begin
        e = qa.pop_front();
        exp_reg = e.rid; exp_data = e.data; b_first = 1'b1;
      end else if (gb) begin
        e = qb.pop_front();
        exp_reg = e.rid; exp_data = e.data; b_first = 1'b0;
      end
      a_acc_last = a_valid && sa < 2;
      b_acc_last = b_valid && sb < 2;
      if (a_acc_last && a_reg != 4'd0) qa.push_back({a_reg, a_data});
      if (b_acc_last && b_reg != 4'd0) qb.push_back({b_reg, b_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
    a_reg = 4'd0; b_reg = 4'd0; a_data = 16'd0; b_data = 16'd0;
  endtask

  initial begin
    logic [3:0] ra, rb;
    bit         have_prev, prev_b, saw_a_full, saw_b_full;

    idle_inputs();
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_WriteReg", 32'(WriteReg), 32'd0);
    check("rst_DstReg", 32'(DstReg), 32'd0);
    check("rst_DstData", 32'(DstData), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_pend", 32'({pend1, pend2}), 32'd0);

    // Single write: two-edge latency, pend only in the intervening cycle.
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hBEEF; SrcReg1 = 4'd3;
    step();
    idle_inputs();
    check("beef_pend_mid", 32'(pend1), 32'd1);
    check("beef_we_mid", 32'(WriteReg), 32'd0);
    step();
    check("beef_we", 32'(WriteReg), 32'd1);
    check("beef_reg", 32'(DstReg), 32'd3);
    check("beef_data", 32'(DstData), 32'hBEEF);
    check("beef_pend_after", 32'(pend1), 32'd0);
    step();
    check("beef_we_once", 32'(WriteReg), 32'd0);

    // Both ports busy from reset: strictly alternating, A first.
    rst = 1'b1; step(); rst = 1'b0;
    ra = 4'd1; rb = 4'd9;
    have_prev = 1'b0; prev_b = 1'b0; saw_a_full = 1'b0; saw_b_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; a_reg = ra; a_data = 16'($urandom);
      b_valid = 1'b1; b_reg = rb; b_data = 16'($urandom);
      SrcReg1 = ra; SrcReg2 = rb;
      if (!a_ready) saw_a_full = 1'b1;
      if (!b_ready) saw_b_full = 1'b1;
      step();
      if (a_acc_last) ra = (ra == 4'd7) ? 4'd1 : ra + 4'd1;
      if (b_acc_last) rb = (rb == 4'd15) ? 4'd9 : rb + 4'd1;
      if (WriteReg) begin
        if (!have_prev) check("alt_first_is_A", 32'(DstReg < 4'd9), 32'd1);
        else check("alt_switch", 32'(DstReg >= 4'd9), 32'(!prev_b));
        have_prev = 1'b1;
        prev_b = (DstReg >= 4'd9);
      end
    end
    check("busy_a_ready_dropped", 32'(saw_a_full), 32'd1);
    check("busy_b_ready_dropped", 32'(saw_b_full), 32'd1);
    idle_inputs();
    repeat (6) step();

    // R0 write on port B is accepted and discarded.
    b_valid = 1'b1; b_reg = 4'd0; b_data = 16'hFFFF; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    check("r0_b_ready", 32'(b_ready), 32'd1);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("r0_no_write", 32'(WriteReg), 32'd0);
      check("r0_no_pend", 32'({pend1, pend2}), 32'd0);
      step();
    end

    // Hold for four cycles while A offers three requests.
    hold = 1'b1;
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h1111; step();
    a_reg = 4'd5; a_data = 16'h2222; step();
    a_reg = 4'd7; a_data = 16'h3333;
    check("hold_a_ready_full", 32'(a_ready), 32'd0);
    step();
    check("hold_no_write", 32'(WriteReg), 32'd0);
    a_valid = 1'b0; step();
    check("hold_no_write_end", 32'(WriteReg), 32'd0);
    hold = 1'b0; step();
    check("drain1_we", 32'(WriteReg), 32'd1);
    check("drain1_reg", 32'(DstReg), 32'd2);
    step();
    check("drain2_we", 32'(WriteReg), 32'd1);
    check("drain2_reg", 32'(DstReg), 32'd5);
    step();
    check("drain_done", 32'(WriteReg), 32'd0);

    // Port A alone, back to back.
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 3); a_reg = 4'(4 + i); a_data = 16'(i);
      check("solo_a_ready", 32'(a_ready), 32'd1);
      step();
      if (i >= 1 && i <= 3) begin
        check("solo_we", 32'(WriteReg), 32'd1);
        check("solo_reg", 32'(DstReg), 32'(3 + i));
      end
    end
    idle_inputs();
    step();

    // Reset with entries queued and one staged.
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_reg = 4'(1 + i); a_data = 16'(16'hA000 + i);
      b_valid = 1'b1; b_reg = 4'(9 + i); b_data = 16'(16'hB000 + i);
      step();
    end
    idle_inputs();
    check("pre_rst_staged", 32'(WriteReg), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("post_rst_we", 32'(WriteReg), 32'd0);
    check("post_rst_ready", 32'({a_ready, b_ready}), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_write", 32'(WriteReg), 32'd0);
    end

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_reg   = 4'($urandom_range(0, 15));
      b_reg   = 4'($urandom_range(0, 15));
      a_data  = 16'($urandom);
      b_data  = 16'($urandom);
      hold    = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      SrcReg1 = 4'($urandom_range(0, 15));
      SrcReg2 = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
